comperator_block_scheduler: RTL and testbench

Sequences the left and right block readers of the stereoscopic comparator. It fires a single go pulse to both readers, then waits until each has reported done; the two may finish in different cycles. It captures both blocks and presents the pair downstream over a valid/ready handshake, tagged with column/row position. It also tracks line and frame boundaries so the disparity datapath receives an ordered stream of block pairs per frame.

---
 rtl/comperator_pkg.sv | 18 +
 rtl/comperator_pos_counter.sv | 54 +++++
 rtl/comperator_block_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_comperator_block_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comperator_pkg.sv
// Shared constants for the stereoscopic comparator: pixel width, block geometry
// and the block scheduler's state encodings.
package comperator_pkg;

    localparam int unsigned DATA_WIDTH         = 24;
    localparam int unsigned BLOCK_SIZE_DEFAULT = 8;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StIssue   = 3'd1;
    localparam logic [2:0] StWait    = 3'd2;
    localparam logic [2:0] StPresent = 3'd3;
    localparam logic [2:0] StFend    = 3'd4;

    function automatic int unsigned block_width(input int unsigned block_size);
        return block_size * DATA_WIDTH;
    endfunction

endpackage

// File: rtl/comperator_pos_counter.sv
// Column/row position tracker for block pairs; advances once per accepted pair
// and flags the last block of a line and of a frame.
module comperator_pos_counter #(
    parameter int unsigned BLOCKS_PER_LINE = 80,
    parameter int unsigned LINES_PER_FRAME = 480
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        advance_i,
    input  logic        clear_i,
    output logic [15:0] col_o,
    output logic [15:0] row_o,
    output logic        eol_o,
    output logic        eof_o
);

    localparam logic [15:0] ColLast = 16'(BLOCKS_PER_LINE - 1);
    localparam logic [15:0] RowLast = 16'(LINES_PER_FRAME - 1);

    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;

    assign eol_o = (col_q == ColLast);
    assign eof_o = eol_o && (row_q == RowLast);
    assign col_o = col_q;
    assign row_o = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (eol_o) begin
                col_d = '0;
                row_d = eof_o ? 16'd0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/comperator_block_scheduler.sv
// Issues go to the left/right block readers, collects both blocks and presents the
// pair downstream with position tags. Optional watchdog: COMPERATOR_SCHED_TIMEOUT_EN.
module comperator_block_scheduler
    import comperator_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE      = BLOCK_SIZE_DEFAULT,
    parameter int unsigned BLOCKS_PER_LINE = 80,
    parameter int unsigned LINES_PER_FRAME = 480,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                start,
    output logic                                busy,
    output logic                                l_go,
    input  logic                                l_done,
    input  logic [block_width(BLOCK_SIZE)-1:0] l_block,
    input  logic [15:0]                         l_count,
    output logic                                r_go,
    input  logic                                r_done,
    input  logic [block_width(BLOCK_SIZE)-1:0] r_block,
    input  logic [15:0]                         r_count,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [block_width(BLOCK_SIZE)-1:0] m_l_block,
    output logic [block_width(BLOCK_SIZE)-1:0] m_r_block,
    output logic [15:0]                         m_count,
    output logic [15:0]                         m_col,
    output logic [15:0]                         m_row,
    output logic                                m_eol,
    output logic                                m_eof,
    output logic                                frame_done,
    output logic                                err_mismatch
`ifdef COMPERATOR_SCHED_TIMEOUT_EN
    ,
    output logic                                err_timeout
`endif
);

    localparam int unsigned BlockW = block_width(BLOCK_SIZE);

    logic [2:0]        state_q, state_d;
    logic              busy_q, busy_d;
    logic              l_seen_q, l_seen_d;
    logic              r_seen_q, r_seen_d;
    logic [BlockW-1:0] l_blk_q, l_blk_d;
    logic [BlockW-1:0] r_blk_q, r_blk_d;
    logic [15:0]       l_cnt_q, l_cnt_d;
    logic [15:0]       r_cnt_q, r_cnt_d;
    logic              err_mm_q, err_mm_d;
    logic              accept;
    logic              pos_clear;

`ifdef COMPERATOR_SCHED_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        err_to_q, err_to_d;
    assign err_timeout = err_to_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

    assign accept       = (state_q == StPresent) && m_ready;
    assign busy         = busy_q;
    assign l_go         = (state_q == StIssue);
    assign r_go         = (state_q == StIssue);
    assign m_valid      = (state_q == StPresent);
    assign frame_done   = (state_q == StFend);
    assign m_l_block    = l_blk_q;
    assign m_r_block    = r_blk_q;
    assign m_count      = (l_cnt_q < r_cnt_q) ? l_cnt_q : r_cnt_q;
    assign err_mismatch = err_mm_q;

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        l_seen_d  = l_seen_q;
        r_seen_d  = r_seen_q;
        l_blk_d   = l_blk_q;
        r_blk_d   = r_blk_q;
        l_cnt_d   = l_cnt_q;
        r_cnt_d   = r_cnt_q;
        err_mm_d  = err_mm_q;
        pos_clear = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    busy_d  = 1'b1;
                end
            end
            StIssue: begin
                // done from the previous request may still be high here; ignore it
                l_seen_d = 1'b0;
                r_seen_d = 1'b0;
                state_d  = StWait;
            end
            StWait: begin
                if (l_done && !l_seen_q) begin
                    l_seen_d = 1'b1;
                    l_blk_d  = l_block;
                    l_cnt_d  = l_count;
                end
                if (r_done && !r_seen_q) begin
                    r_seen_d = 1'b1;
                    r_blk_d  = r_block;
                    r_cnt_d  = r_count;
                end
                if (l_seen_d && r_seen_d) begin
                    state_d = StPresent;
                    if (l_cnt_d != r_cnt_d) begin
                        err_mm_d = 1'b1;
                    end
                end
            end
            StPresent: begin
                if (m_ready) begin
                    if (m_eof) begin
                        state_d = StFend;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = start ? StIssue : StIdle;
                    end
                end
            end
            StFend: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef COMPERATOR_SCHED_TIMEOUT_EN
        wd_d     = (state_q == StWait) ? wd_q + 16'd1 : 16'd0;
        err_to_d = err_to_q;
        // A pair completing in the final watchdog cycle still wins
        if ((state_q == StWait) && (state_d == StWait) &&
            (wd_q == 16'(TIMEOUT_CYCLES - 1))) begin
            err_to_d  = 1'b1;
            busy_d    = 1'b0;
            state_d   = StIdle;
            pos_clear = 1'b1;
            wd_d      = '0;
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= StIdle;
            busy_q   <= 1'b0;
            l_seen_q <= 1'b0;
            r_seen_q <= 1'b0;
            l_blk_q  <= '0;
            r_blk_q  <= '0;
            l_cnt_q  <= '0;
            r_cnt_q  <= '0;
            err_mm_q <= 1'b0;
`ifdef COMPERATOR_SCHED_TIMEOUT_EN
            wd_q     <= '0;
            err_to_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            l_seen_q <= l_seen_d;
            r_seen_q <= r_seen_d;
            l_blk_q  <= l_blk_d;
            r_blk_q  <= r_blk_d;
            l_cnt_q  <= l_cnt_d;
            r_cnt_q  <= r_cnt_d;
            err_mm_q <= err_mm_d;
`ifdef COMPERATOR_SCHED_TIMEOUT_EN
            wd_q     <= wd_d;
            err_to_q <= err_to_d;
`endif
        end
    end

    comperator_pos_counter #(
        .BLOCKS_PER_LINE(BLOCKS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME)
    ) u_pos (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .advance_i(accept),
        .clear_i  (pos_clear),
        .col_o    (m_col),
        .row_o    (m_row),
        .eol_o    (m_eol),
        .eof_o    (m_eof)
    );

endmodule

// File: tb/tb_comperator_block_scheduler.sv
// Directed bench for comperator_block_scheduler with a 4x2-block frame; readers are
// modelled by driving done/block/count by hand.
module tb_comperator_block_scheduler;

    localparam int unsigned BS  = 8;
    localparam int unsigned BW  = BS * 24;
    localparam int unsigned BPL = 4;
    localparam int unsigned LPF = 2;

    logic          aclk = 1'b0;
    logic          aresetn, start, l_done, r_done, m_ready;
    logic [BW-1:0] l_block, r_block;
    logic [15:0]   l_count, r_count;
    logic          busy, l_go, r_go, m_valid, m_eol, m_eof, frame_done, err_mismatch;
    logic [BW-1:0] m_l_block, m_r_block;
    logic [15:0]   m_count, m_col, m_row;
`ifdef COMPERATOR_SCHED_TIMEOUT_EN
    logic          err_timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    comperator_block_scheduler #(
        .BLOCK_SIZE     (BS),
        .BLOCKS_PER_LINE(BPL),
        .LINES_PER_FRAME(LPF),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .start       (start),
        .busy        (busy),
        .l_go        (l_go),
        .l_done      (l_done),
        .l_block     (l_block),
        .l_count     (l_count),
        .r_go        (r_go),
        .r_done      (r_done),
        .r_block     (r_block),
        .r_count     (r_count),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_l_block   (m_l_block),
        .m_r_block   (m_r_block),
        .m_count     (m_count),
        .m_col       (m_col),
        .m_row       (m_row),
        .m_eol       (m_eol),
        .m_eof       (m_eof),
        .frame_done  (frame_done),
        .err_mismatch(err_mismatch)
`ifdef COMPERATOR_SCHED_TIMEOUT_EN
        ,
        .err_timeout (err_timeout)
`endif
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        start   = 1'b0;
        l_done  = 1'b0;
        r_done  = 1'b0;
        m_ready = 1'b0;
        l_block = '0;
        r_block = '0;
        l_count = '0;
        r_count = '0;
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy, l_go, r_go, m_valid, m_eol, m_eof, frame_done, err_mismatch} !== 8'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {busy, l_go, r_go, m_valid, m_eol, m_eof, frame_done, err_mismatch});
        end
        checks++;
        if ({m_col, m_row, m_count} !== 48'h0 || m_l_block !== '0 || m_r_block !== '0) begin
            errors++;
            $display("FAIL reset_data: got col %0d row %0d count %0d expected all zero",
                     m_col, m_row, m_count);
        end
    endtask

    task automatic test_same_cycle();
        logic [BW-1:0] pa, pb;
        pa = {8{24'hA1B2C3}};
        pb = {8{24'h102030}};
        do_reset();
        start   = 1'b1;
        m_ready = 1'b1;
        tick();
        checks++;
        if ({l_go, r_go, busy} !== 3'b111) begin
            errors++;
            $display("FAIL same_go: got go/busy %b expected 111", {l_go, r_go, busy});
        end
        tick();
        checks++;
        if ({l_go, r_go, m_valid} !== 3'b000) begin
            errors++;
            $display("FAIL same_wait: got go/valid %b expected 000", {l_go, r_go, m_valid});
        end
        l_done = 1'b1; r_done = 1'b1; l_block = pa; r_block = pb; l_count = 8; r_count = 8;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_l_block !== pa || m_r_block !== pb ||
            m_col !== 16'd0 || m_row !== 16'd0 || m_count !== 16'd8) begin
            errors++;
            $display("FAIL same_pair: got valid %b col %0d row %0d count %0d expected 1 0 0 8",
                     m_valid, m_col, m_row, m_count);
        end
        l_done = 1'b0; r_done = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (m_valid !== 1'b0 || l_go !== 1'b0 || m_col !== 16'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL park: got valid %b go %b col %0d busy %b expected 0 0 1 1",
                     m_valid, l_go, m_col, busy);
        end
        start = 1'b1;
        tick();
        checks++;
        if (l_go !== 1'b1 || m_col !== 16'd1) begin
            errors++;
            $display("FAIL resume: got go %b col %0d expected 1 1", l_go, m_col);
        end
    endtask

    task automatic test_skewed();
        logic [BW-1:0] sa, sc;
        sa = {8{24'h111111}};
        sc = {8{24'h333333}};
        do_reset();
        start = 1'b1;
        tick();
        tick();
        l_done = 1'b1; l_block = sa; l_count = 4;
        tick();
        l_block = {8{24'h222222}}; l_count = 9;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b0 || l_go !== 1'b0) begin
                errors++;
                $display("FAIL skew_wait%0d: got valid %b go %b expected 0 0", i, m_valid, l_go);
            end
        end
        r_done = 1'b1; r_block = sc; r_count = 4;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_l_block !== sa || m_r_block !== sc || err_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL skew_pair: got valid %b lblk %h err %b expected 1 %h 0",
                     m_valid, m_l_block[23:0], err_mismatch, sa[23:0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || l_go !== 1'b0 || r_go !== 1'b0 || m_l_block !== sa) begin
                errors++;
                $display("FAIL skew_hold%0d: got valid %b go %b expected 1 0", i, m_valid, l_go);
            end
        end
        m_ready = 1'b1;
        tick();
        checks++;
        if (l_go !== 1'b1 || m_valid !== 1'b0 || m_col !== 16'd1) begin
            errors++;
            $display("FAIL skew_next: got go %b valid %b col %0d expected 1 0 1",
                     l_go, m_valid, m_col);
        end
    endtask

    task automatic test_backpressure();
        logic [BW-1:0] qa, qb;
        qa = {8{24'h5A5A5A}};
        qb = {8{24'hC3C3C3}};
        do_reset();
        start = 1'b1;
        tick();
        tick();
        l_done = 1'b1; r_done = 1'b1; l_block = qa; r_block = qb; l_count = 3; r_count = 3;
        tick();
        l_done = 1'b0; r_done = 1'b0; l_block = ~qa; r_block = ~qb; l_count = 1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_l_block !== qa || m_r_block !== qb ||
                m_count !== 16'd3 || m_col !== 16'd0 || l_go !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable%0d: got valid %b count %0d col %0d expected 1 3 0",
                         i, m_valid, m_count, m_col);
            end
            tick();
        end
        m_ready = 1'b1;
        tick();
        checks++;
        if ({l_go, r_go, m_valid} !== 3'b110) begin
            errors++;
            $display("FAIL bp_next_go: got go/valid %b expected 110", {l_go, r_go, m_valid});
        end
    endtask

    task automatic test_frame();
        do_reset();
        start   = 1'b1;
        m_ready = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (l_go !== 1'b1) begin
                errors++;
                $display("FAIL frame_go%0d: got %b expected 1", i, l_go);
            end
            tick();
            l_done = 1'b1; r_done = 1'b1; l_count = 16; r_count = 16;
            l_block = BW'(100 + i); r_block = BW'(200 + i);
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_col !== 16'(i % 4) || m_row !== 16'(i / 4) ||
                m_eol !== (i % 4 == 3) || m_eof !== (i == 7) || frame_done !== 1'b0 ||
                busy !== 1'b1 || m_l_block !== BW'(100 + i)) begin
                errors++;
                $display("FAIL frame_pair%0d: got col %0d row %0d eol %b eof %b expected %0d %0d %b %b",
                         i, m_col, m_row, m_eol, m_eof, i % 4, i / 4, (i % 4 == 3), (i == 7));
            end
            l_done = 1'b0; r_done = 1'b0;
            if (i == 7) start = 1'b0;
            tick();
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || m_col !== 16'd0 || m_row !== 16'd0 ||
            m_valid !== 1'b0) begin
            errors++;
            $display("FAIL frame_end: got done %b busy %b col %0d row %0d expected 1 0 0 0",
                     frame_done, busy, m_col, m_row);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0 || l_go !== 1'b0) begin
            errors++;
            $display("FAIL frame_idle: got done %b go %b expected 0 0", frame_done, l_go);
        end
        start = 1'b1;
        tick();
        checks++;
        if (l_go !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL frame_restart: got go %b busy %b expected 1 1", l_go, busy);
        end
    endtask

    task automatic test_mismatch();
        do_reset();
        start   = 1'b1;
        m_ready = 1'b1;
        tick();
        tick();
        l_done = 1'b1; r_done = 1'b1; l_count = 7; r_count = 5;
        tick();
        checks++;
        if (m_valid !== 1'b1 || m_count !== 16'd5 || err_mismatch !== 1'b1) begin
            errors++;
            $display("FAIL mm_pair: got valid %b count %0d err %b expected 1 5 1",
                     m_valid, m_count, err_mismatch);
        end
        l_done = 1'b0; r_done = 1'b0; start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        tick();
        l_done = 1'b1; r_done = 1'b1; l_count = 6; r_count = 6;
        tick();
        checks++;
        if (err_mismatch !== 1'b1 || m_count !== 16'd6) begin
            errors++;
            $display("FAIL mm_sticky: got err %b count %0d expected 1 6", err_mismatch, m_count);
        end
        l_done = 1'b0; r_done = 1'b0;
        aresetn = 1'b0;
        tick();
        checks++;
        if (err_mismatch !== 1'b0) begin
            errors++;
            $display("FAIL mm_clear: got %b expected 0", err_mismatch);
        end
        aresetn = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        start   = 1'b1;
        m_ready = 1'b1;
        tick();
        tick();
        l_done = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait: got busy %b valid %b expected 1 0", busy, m_valid);
        end
        aresetn = 1'b0;
        tick();
        checks++;
        if ({busy, l_go, r_go, m_valid, frame_done, err_mismatch} !== 6'b0 ||
            m_col !== 16'd0 || m_l_block !== '0) begin
            errors++;
            $display("FAIL rst_outputs: got %b col %0d expected 000000 0",
                     {busy, l_go, r_go, m_valid, frame_done, err_mismatch}, m_col);
        end
        tick();
        checks++;
        if (l_go !== 1'b0) begin
            errors++;
            $display("FAIL rst_nogo: got %b expected 0", l_go);
        end
        aresetn = 1'b1;
        l_done  = 1'b0;
        tick();
        checks++;
        if (l_go !== 1'b1 || m_col !== 16'd0) begin
            errors++;
            $display("FAIL rst_from_idle: got go %b col %0d expected 1 0", l_go, m_col);
        end
    endtask

`ifdef COMPERATOR_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        start = 1'b1;
        tick();
        tick();
        l_done = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (err_timeout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL to_early: got err %b busy %b expected 0 1", err_timeout, busy);
        end
        tick();
        checks++;
        if (err_timeout !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL to_fire: got err %b busy %b valid %b expected 1 0 0",
                     err_timeout, busy, m_valid);
        end
        l_done = 1'b0;
        start  = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_same_cycle();
        test_skewed();
        test_backpressure();
        test_frame();
        test_mismatch();
        test_reset_mid_wait();
`ifdef COMPERATOR_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
